// File: rtl/trace_pkg.sv
// Shared trace types and constants for the cosimulation trace path.
// The reorder buffer carries trace_event_t packed into an opaque payload.
package trace_pkg;

    localparam int unsigned TRACE_DROP_COUNT_WIDTH = 16;

    typedef enum logic [2:0] {
        INVALID,
        SWRITEBACK,
        VWRITEBACK,
        STORE,
        INTERRUPT
    } trace_event_type_e;

    typedef struct packed {
        trace_event_type_e event_type;
        logic [31:0]       pc;
        logic [3:0]        thread_idx;
        logic [4:0]        writeback_reg;
        logic [31:0]       addr;
        logic [15:0]       mask;
        logic [31:0]       data;
    } trace_event_t;

endpackage

// File: rtl/trace_reorder_buffer_if.sv
// Producer/consumer bundle of the trace reorder buffer.
// master = surrounding pipeline and formatter, slave = the buffer itself.
interface trace_reorder_buffer_if
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned NUM_CHANNELS  = 3,
    parameter int unsigned PAYLOAD_WIDTH = 64
);
    localparam int unsigned KW = $clog2(DEPTH);
    localparam int unsigned CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int unsigned OW = $clog2(DEPTH + 1);

    logic [NUM_CHANNELS-1:0]                    in_valid;
    logic [NUM_CHANNELS-1:0][PAYLOAD_WIDTH-1:0] in_payload;
    logic                                       kill_en;
    logic [KW-1:0]                              kill_slot;
    logic                                       out_valid;
    logic [PAYLOAD_WIDTH-1:0]                   out_payload;
    logic [CW-1:0]                              out_channel;
    logic                                       out_ready;
    logic                                       collision;
    logic [OW-1:0]                              occupancy;
    logic [TRACE_DROP_COUNT_WIDTH-1:0]          drop_count;

    modport master (
        output in_valid, in_payload, kill_en, kill_slot, out_ready,
        input  out_valid, out_payload, out_channel, collision, occupancy, drop_count
    );

    modport slave (
        input  in_valid, in_payload, kill_en, kill_slot, out_ready,
        output out_valid, out_payload, out_channel, collision, occupancy, drop_count
    );

endinterface

// File: rtl/trace_reorder_slot.sv
// One queue entry: chooses between hold, shift-in, kill and a channel insert,
// and reports which requesting channels lost this slot.
module trace_reorder_slot
    import trace_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS  = 3,
    parameter int unsigned PAYLOAD_WIDTH = 64,
    parameter int unsigned CHANNEL_WIDTH = 2
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       i_adv,
    input  logic                                       i_up_valid,
    input  logic [CHANNEL_WIDTH-1:0]                   i_up_channel,
    input  logic [PAYLOAD_WIDTH-1:0]                   i_up_payload,
    input  logic                                       i_kill,
    input  logic [NUM_CHANNELS-1:0]                    i_req,
    input  logic [NUM_CHANNELS-1:0][PAYLOAD_WIDTH-1:0] i_payload,
    output logic                                       o_valid,
    output logic [CHANNEL_WIDTH-1:0]                   o_channel,
    output logic [PAYLOAD_WIDTH-1:0]                   o_payload,
    output logic [NUM_CHANNELS-1:0]                    o_drop,
    output logic                                       o_ins,
    output logic                                       o_kill_eff
);
    logic                     r_valid;
    logic [CHANNEL_WIDTH-1:0] r_channel;
    logic [PAYLOAD_WIDTH-1:0] r_payload;

    logic                     w_src_valid;
    logic [CHANNEL_WIDTH-1:0] w_src_channel;
    logic [PAYLOAD_WIDTH-1:0] w_src_payload;
    logic                     w_incumbent;
    logic                     w_any;
    logic [NUM_CHANNELS-1:0]  w_win_oh;
    logic [CHANNEL_WIDTH-1:0] w_win_channel;
    logic [PAYLOAD_WIDTH-1:0] w_win_payload;
    logic                     w_next_valid;
    logic [CHANNEL_WIDTH-1:0] w_next_channel;
    logic [PAYLOAD_WIDTH-1:0] w_next_payload;

    always_comb begin
        w_src_valid   = i_adv ? i_up_valid   : r_valid;
        w_src_channel = i_adv ? i_up_channel : r_channel;
        w_src_payload = i_adv ? i_up_payload : r_payload;

        // A kill frees the slot before inserts are judged, so a same-slot insert lands cleanly.
        o_kill_eff  = i_kill && w_src_valid;
        w_incumbent = w_src_valid && !i_kill;

        w_any         = 1'b0;
        w_win_oh      = '0;
        w_win_channel = '0;
        w_win_payload = '0;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            if (i_req[c] && !w_any) begin
                w_any         = 1'b1;
                w_win_oh[c]   = 1'b1;
                w_win_channel = CHANNEL_WIDTH'(c);
                w_win_payload = i_payload[c];
            end
        end

        o_ins  = w_any && !w_incumbent;
        o_drop = i_req & ~(w_win_oh & {NUM_CHANNELS{o_ins}});

        if (o_ins) begin
            w_next_valid   = 1'b1;
            w_next_channel = w_win_channel;
            w_next_payload = w_win_payload;
        end else begin
            w_next_valid   = w_incumbent;
            w_next_channel = w_src_channel;
            w_next_payload = w_src_payload;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_channel <= '0;
            r_payload <= '0;
        end else begin
            r_valid   <= w_next_valid;
            r_channel <= w_next_channel;
            r_payload <= w_next_payload;
        end
    end

    assign o_valid   = r_valid;
    assign o_channel = r_channel;
    assign o_payload = r_payload;

endmodule

// File: rtl/trace_reorder_buffer.sv
// Reorder queue restoring issue order of trace events from fixed-latency producers.
// Optional feature: define TRACE_DROP_COUNT_EN to build the saturating drop counter.
module trace_reorder_buffer
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned NUM_CHANNELS  = 3,
    parameter int unsigned PAYLOAD_WIDTH = 64,
    parameter int unsigned CHANNEL_SLOT [NUM_CHANNELS] = '{0, 3, 4}
) (
    input  logic                  clk,
    input  logic                  reset,
    trace_reorder_buffer_if.slave bus
);
    localparam int unsigned CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int unsigned OW = $clog2(DEPTH + 1);
    localparam int unsigned DW = $clog2(NUM_CHANNELS + 1);

    logic                     w_adv;
    logic                     w_pop;
    logic [DEPTH-1:0]         w_valid;
    logic [CW-1:0]            w_channel [DEPTH];
    logic [PAYLOAD_WIDTH-1:0] w_payload [DEPTH];
    logic [NUM_CHANNELS-1:0]  w_req     [DEPTH];
    logic [NUM_CHANNELS-1:0]  w_drop    [DEPTH];
    logic [DEPTH-1:0]         w_kill;
    logic [DEPTH-1:0]         w_ins;
    logic [DEPTH-1:0]         w_kill_eff;
    logic [OW-1:0]            w_num_ins;
    logic [OW-1:0]            w_num_kill;
    logic [DW-1:0]            w_num_drop;
    logic [OW-1:0]            w_occ_next;

    logic [OW-1:0]            r_occupancy;
    logic                     r_collision;

    assign w_adv = !w_valid[0] || bus.out_ready;
    assign w_pop = w_valid[0] && bus.out_ready;

    // Targets and kill positions are resolved into post-edge slot numbering.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_kill[i] = bus.kill_en &&
                        (w_adv ? (32'(bus.kill_slot) == i + 1) : (32'(bus.kill_slot) == i));
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                w_req[i][c] = bus.in_valid[c] &&
                              ((CHANNEL_SLOT[c] + (w_adv ? 32'd0 : 32'd1)) == i);
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic                     w_up_valid;
        logic [CW-1:0]            w_up_channel;
        logic [PAYLOAD_WIDTH-1:0] w_up_payload;

        if (g == DEPTH - 1) begin : g_tail
            assign w_up_valid   = 1'b0;
            assign w_up_channel = '0;
            assign w_up_payload = '0;
        end else begin : g_body
            assign w_up_valid   = w_valid[g+1];
            assign w_up_channel = w_channel[g+1];
            assign w_up_payload = w_payload[g+1];
        end

        trace_reorder_slot #(
            .NUM_CHANNELS (NUM_CHANNELS),
            .PAYLOAD_WIDTH(PAYLOAD_WIDTH),
            .CHANNEL_WIDTH(CW)
        ) u_slot (
            .clk         (clk),
            .reset       (reset),
            .i_adv       (w_adv),
            .i_up_valid  (w_up_valid),
            .i_up_channel(w_up_channel),
            .i_up_payload(w_up_payload),
            .i_kill      (w_kill[g]),
            .i_req       (w_req[g]),
            .i_payload   (bus.in_payload),
            .o_valid     (w_valid[g]),
            .o_channel   (w_channel[g]),
            .o_payload   (w_payload[g]),
            .o_drop      (w_drop[g]),
            .o_ins       (w_ins[g]),
            .o_kill_eff  (w_kill_eff[g])
        );
    end

    always_comb begin
        w_num_ins  = '0;
        w_num_kill = '0;
        w_num_drop = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_num_ins  = w_num_ins + OW'(w_ins[i]);
            w_num_kill = w_num_kill + OW'(w_kill_eff[i]);
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                w_num_drop = w_num_drop + DW'(w_drop[i][c]);
            end
        end
    end

    assign w_occ_next = r_occupancy + w_num_ins - OW'(w_pop) - w_num_kill;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_occupancy <= '0;
            r_collision <= 1'b0;
        end else begin
            r_occupancy <= w_occ_next;
            r_collision <= (w_num_drop != '0);
        end
    end

`ifdef TRACE_DROP_COUNT_EN
    localparam int unsigned SW = TRACE_DROP_COUNT_WIDTH + 1;

    logic [TRACE_DROP_COUNT_WIDTH-1:0] r_drop_count;
    logic [SW-1:0]                     w_drop_sum;

    assign w_drop_sum = {1'b0, r_drop_count} + SW'(w_num_drop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_count <= '0;
        end else begin
            r_drop_count <= w_drop_sum[SW-1] ? '1 : w_drop_sum[SW-2:0];
        end
    end

    assign bus.drop_count = r_drop_count;
`else
    assign bus.drop_count = '0;
`endif

    assign bus.out_valid   = w_valid[0];
    assign bus.out_channel = w_channel[0];
    assign bus.out_payload = w_payload[0];
    assign bus.collision   = r_collision;
    assign bus.occupancy   = r_occupancy;

endmodule

// File: tb/tb_trace_reorder_buffer.sv
// Scoreboard bench: two buffers (default slots and a shared-slot variant) driven
// with identical stimulus and compared against a positioned-event list model.
module tb_trace_reorder_buffer;
    import trace_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned NC    = 3;
    localparam int unsigned PW    = 64;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    trace_reorder_buffer_if #(.DEPTH(DEPTH), .NUM_CHANNELS(NC), .PAYLOAD_WIDTH(PW)) bus_a ();
    trace_reorder_buffer_if #(.DEPTH(DEPTH), .NUM_CHANNELS(NC), .PAYLOAD_WIDTH(PW)) bus_b ();

    trace_reorder_buffer #(
        .DEPTH(DEPTH), .NUM_CHANNELS(NC), .PAYLOAD_WIDTH(PW), .CHANNEL_SLOT('{0, 3, 4})
    ) u_dut_a (.clk(clk), .reset(reset), .bus(bus_a));

    trace_reorder_buffer #(
        .DEPTH(DEPTH), .NUM_CHANNELS(NC), .PAYLOAD_WIDTH(PW), .CHANNEL_SLOT('{0, 3, 3})
    ) u_dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    typedef struct {int inst; int pos; int ch; logic [63:0] pl;} ev_t;
    typedef struct {int inst; int ch; logic [63:0] pl;} ex_t;
    typedef struct {int inst; int cyc; int occ; int coll; int drop; bit hv; int hch; logic [63:0] hpl;} st_t;

    ev_t mev[$];
    ex_t exq[$];
    st_t stq[$];
    int  cs [2][3] = '{'{0, 3, 4}, '{0, 3, 3}};
    int  m_drop [2] = '{0, 0};
    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc_cnt = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    function automatic int find(input int k, input int pos);
        foreach (mev[i]) if (mev[i].inst == k && mev[i].pos == pos) return i;
        return -1;
    endfunction

    function automatic int count(input int k);
        int n = 0;
        foreach (mev[i]) if (mev[i].inst == k) n++;
        return n;
    endfunction

    // Reference: events carry a queue position; an edge pops position 0 and moves the rest down.
    task automatic model(input int k, input bit rst, input bit [2:0] v, input logic [2:0][63:0] p,
                         input bit kil, input int ks, input bit rdy);
        bit  adv;
        int  idx;
        int  drops;
        int  t;
        st_t s;
        adv   = (find(k, 0) < 0) || rdy;
        drops = 0;
        if (rst) begin
            for (int i = mev.size() - 1; i >= 0; i--) if (mev[i].inst == k) mev.delete(i);
            m_drop[k] = 0;
        end else begin
            if (kil && !(adv && ks == 0)) begin
                idx = find(k, ks);
                if (idx >= 0) mev.delete(idx);
            end
            if (adv) begin
                idx = find(k, 0);
                if (idx >= 0) begin
                    exq.push_back('{k, mev[idx].ch, mev[idx].pl});
                    mev.delete(idx);
                end
                foreach (mev[i]) if (mev[i].inst == k) mev[i].pos--;
            end
            for (int c = 0; c < 3; c++) begin
                if (v[c]) begin
                    t = cs[k][c] + (adv ? 0 : 1);
                    if (find(k, t) >= 0) drops++;
                    else mev.push_back('{k, t, c, p[c]});
                end
            end
`ifdef TRACE_DROP_COUNT_EN
            m_drop[k] = (m_drop[k] + drops > 65535) ? 65535 : m_drop[k] + drops;
`else
            m_drop[k] = 0;
`endif
        end
        idx    = find(k, 0);
        s.inst = k;
        s.cyc  = cyc_cnt + 1;
        s.occ  = count(k);
        s.coll = (drops > 0) ? 1 : 0;
        s.drop = m_drop[k];
        s.hv   = (idx >= 0);
        s.hch  = (idx >= 0) ? mev[idx].ch : 0;
        s.hpl  = (idx >= 0) ? mev[idx].pl : 64'd0;
        stq.push_back(s);
    endtask

    task automatic step(input bit rst, input bit [2:0] v, input bit kil, input bit [2:0] ks, input bit rdy);
        logic [2:0][63:0] p;
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) p[c] = {$urandom, $urandom};
        reset           = rst;
        bus_a.in_valid  = v;  bus_b.in_valid  = v;
        bus_a.in_payload = p; bus_b.in_payload = p;
        bus_a.kill_en   = kil; bus_b.kill_en  = kil;
        bus_a.kill_slot = ks; bus_b.kill_slot = ks;
        bus_a.out_ready = rdy; bus_b.out_ready = rdy;
        model(0, rst, v, p, kil, int'(ks), rdy);
        model(1, rst, v, p, kil, int'(ks), rdy);
    endtask

    task automatic mon(input int k, input logic ov, input logic rdy, input logic [63:0] pl,
                       input logic [1:0] ch, input logic coll, input logic [3:0] occ, input logic [15:0] dc);
        int idx;
        string tag;
        tag = (k == 0) ? "a" : "b";
        idx = -1;
        foreach (stq[i]) if (stq[i].inst == k && idx < 0) idx = i;
        if (idx >= 0 && stq[idx].cyc == cyc_cnt) begin
            chk({"occupancy_", tag}, 64'(occ), 64'(stq[idx].occ));
            chk({"collision_", tag}, 64'(coll), 64'(stq[idx].coll));
            chk({"drop_count_", tag}, 64'(dc), 64'(stq[idx].drop));
            chk({"out_valid_", tag}, 64'(ov), 64'(stq[idx].hv));
            if (stq[idx].hv) begin
                chk({"head_payload_", tag}, pl, stq[idx].hpl);
                chk({"head_channel_", tag}, 64'(ch), 64'(stq[idx].hch));
            end
            stq.delete(idx);
        end
        if (ov === 1'b1 && rdy === 1'b1 && reset === 1'b0) begin
            idx = -1;
            foreach (exq[i]) if (exq[i].inst == k && idx < 0) idx = i;
            if (idx < 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL pop_%s: got unexpected payload %0h, required no emission", tag, pl);
            end else begin
                chk({"pop_payload_", tag}, pl, exq[idx].pl);
                chk({"pop_channel_", tag}, 64'(ch), 64'(exq[idx].ch));
                exq.delete(idx);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus_a.out_valid, bus_a.out_ready, bus_a.out_payload, bus_a.out_channel,
            bus_a.collision, bus_a.occupancy, bus_a.drop_count);
        mon(1, bus_b.out_valid, bus_b.out_ready, bus_b.out_payload, bus_b.out_channel,
            bus_b.collision, bus_b.occupancy, bus_b.drop_count);
    end

    initial begin
        int left_a;
        int left_b;
        bus_a.in_valid = '0; bus_a.in_payload = '0; bus_a.kill_en = 1'b0; bus_a.kill_slot = '0; bus_a.out_ready = 1'b0;
        bus_b.in_valid = '0; bus_b.in_payload = '0; bus_b.kill_en = 1'b0; bus_b.kill_slot = '0; bus_b.out_ready = 1'b0;
        step(1, 3'b000, 0, 0, 1);
        step(1, 3'b000, 0, 0, 1);

        // reorder: channel 1 then channel 0 two edges later
        step(0, 3'b010, 0, 0, 1);
        step(0, 3'b000, 0, 0, 1);
        step(0, 3'b001, 0, 0, 1);
        repeat (6) step(0, 3'b000, 0, 0, 1);

        // stall with the channel 2 entry reaching the head
        step(0, 3'b100, 0, 0, 1);
        repeat (3) step(0, 3'b000, 0, 0, 1);
        repeat (3) step(0, 3'b000, 0, 0, 0);
        repeat (4) step(0, 3'b000, 0, 0, 1);

        // same-slot contention (shared slot in instance b, incumbent in a)
        step(0, 3'b110, 0, 0, 1);
        step(0, 3'b010, 0, 0, 1);
        repeat (6) step(0, 3'b000, 0, 0, 1);

        // kill the queued channel 2 entry, then a no-effect kill of slot 0 while advancing
        step(0, 3'b100, 0, 0, 1);
        step(0, 3'b000, 1, 3'd4, 1);
        step(0, 3'b001, 0, 0, 1);
        step(0, 3'b000, 1, 3'd0, 1);
        repeat (4) step(0, 3'b000, 0, 0, 1);

        // mid-stream reset with a concurrent insert
        repeat (5) step(0, 3'b111, 0, 0, 0);
        step(1, 3'b001, 0, 0, 1);
        repeat (4) step(0, 3'b000, 0, 0, 1);

        repeat (3000)
            step($urandom_range(0, 199) == 0, 3'($urandom), $urandom_range(0, 4) == 0,
                 3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);

        // saturation: everything stalled, every channel colliding every edge
        repeat (25000) step(0, 3'b111, 0, 0, 0);

        repeat (12) step(0, 3'b000, 0, 0, 1);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);

        left_a = 0;
        left_b = 0;
        foreach (exq[i]) if (exq[i].inst == 0) left_a++; else left_b++;
        chk("unemitted_a", 64'(left_a), 64'd0);
        chk("unemitted_b", 64'(left_b), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
